// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, default bit timing, frame width
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_WAITHI = 3'd4
   } uart_state_e;

   localparam int DEFAULT_CLKS_PER_BIT = 87;
   localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to 1 so an idle serial line reads idle
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-byte holding register, framing-error and overrun flags
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [TW-1:0]    HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]    FULL_LOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 sample;
   logic                 deliver;
   logic                 handshake;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx_pin),
      .q_o   (rx_s)
   );

   assign sample    = (timer_q == '0);
   assign handshake = valid_q & rx_ready;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      deliver   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               timer_d = HALF_LOAD;
            end
         end
         ST_START: begin
            if (!sample) begin
               timer_d = timer_q - TW'(1);
            end else if (rx_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               timer_d   = FULL_LOAD;
            end
         end
         ST_DATA: begin
            if (!sample) begin
               timer_d = timer_q - TW'(1);
            end else begin
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + IDX_W'(1);
               timer_d            = FULL_LOAD;
               if (bit_idx_q == LAST_IDX) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge.
            if (!sample) begin
               timer_d = timer_q - TW'(1);
            end else if (rx_s) begin
               deliver = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = ST_WAITHI;
            end
         end
         ST_WAITHI: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (deliver && (!valid_q || handshake)) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         ovr_d   = 1'b0;
      end else if (deliver) begin
         ovr_d = 1'b1;
      end else if (handshake) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
